// File: rtl/token_embedder_pkg.sv
// Shared FSM state encoding for the token embedder.
package token_embedder_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    RD_CODE  = 3'd1,
    CHK_CODE = 3'd2,
    RD_EMB   = 3'd3,
    EMIT     = 3'd4,
    DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/token_embedder.sv
// Walks a zero-terminated token code sequence and streams each token's
// embedding row (EMB_DIM elements) out over a valid/ready interface.
// Both SRAMs live in the parent; this block only drives their addresses.
module token_embedder
  import token_embedder_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int EMB_DIM    = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   cs,
  output logic [ADDR_WIDTH-1:0]                  code_addr,
  input  logic [DATA_WIDTH-1:0]                  code_rdata,
  output logic [DATA_WIDTH+$clog2(EMB_DIM)-1:0]  emb_addr,
  input  logic [DATA_WIDTH-1:0]                  emb_rdata,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DATA_WIDTH-1:0]                  out_data,
  output logic                                   out_row_last,
  output logic [ADDR_WIDTH:0]                    token_count,
  output logic                                   done
);

  localparam int EL_W = $clog2(EMB_DIM);
  localparam logic [EL_W-1:0] EL_LAST = EL_W'(EMB_DIM - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   tok_idx;
  logic [EL_W-1:0]         elem;
  logic [DATA_WIDTH-1:0]   code_q;
  logic [ADDR_WIDTH:0]     tok_cnt;

  // Row base is code*EMB_DIM; EMB_DIM is a power of two so concatenation
  // replaces the multiply. Both fields are registers, so the address is
  // stable for the whole EMIT stall.
  assign emb_addr     = {code_q, elem};
  assign code_addr    = tok_idx;
  assign out_valid    = (state == EMIT);
  assign out_data     = emb_rdata;
  assign out_row_last = (state == EMIT) && (elem == EL_LAST);
  assign token_count  = tok_cnt;
  assign done         = (state == DONE);

  // Sequencer: one SRAM read cycle before each code check and each element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tok_idx <= '0;
      elem    <= '0;
      code_q  <= '0;
      tok_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cs) begin
            tok_idx <= '0;
            elem    <= '0;
            tok_cnt <= '0;
            state   <= RD_CODE;
          end
        end
        RD_CODE:  state <= CHK_CODE;
        CHK_CODE: begin
          if (code_rdata == '0) begin
            state <= DONE;
          end else begin
            code_q <= code_rdata;
            state  <= RD_EMB;
          end
        end
        RD_EMB:   state <= EMIT;
        EMIT: begin
          if (out_ready) begin
            if (elem == EL_LAST) begin
              elem    <= '0;
              tok_cnt <= tok_cnt + (ADDR_WIDTH+1)'(1);
              // Last code slot: finish rather than wrap back to slot 0.
              if (&tok_idx) begin
                state <= DONE;
              end else begin
                tok_idx <= tok_idx + ADDR_WIDTH'(1);
                state   <= RD_CODE;
              end
            end else begin
              elem  <= elem + EL_W'(1);
              state <= RD_EMB;
            end
          end
        end
        DONE:     state <= DONE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_token_embedder.sv
// Scoreboard bench for token_embedder with behavioural sync-read SRAMs.
module tb_token_embedder;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int ED = 4;
  localparam int EW = DW + $clog2(ED);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs = 1'b0;
  logic [AW-1:0] code_addr;
  logic [DW-1:0] code_rdata;
  logic [EW-1:0] emb_addr;
  logic [DW-1:0] emb_rdata;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_row_last;
  logic [AW:0]   token_count;
  logic          done;

  logic [DW-1:0] code_mem [2**AW];

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t sb[$];
  beat_t mon_exp;
  int    checks = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  token_embedder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .EMB_DIM(ED)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs),
    .code_addr(code_addr), .code_rdata(code_rdata),
    .emb_addr(emb_addr), .emb_rdata(emb_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row_last(out_row_last), .token_count(token_count), .done(done)
  );

  // Sync-read SRAM models; embedding word equals its own address.
  always @(posedge clk) begin
    code_rdata <= code_mem[code_addr];
    emb_rdata  <= emb_addr[DW-1:0];
  end

  // Scoreboard consumer: every accepted beat is compared in order.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected data=%0d last=%0b", out_data, out_row_last);
      end else begin
        mon_exp = sb.pop_front();
        if (out_data !== mon_exp.data || out_row_last !== mon_exp.last) begin
          failures++;
          $display("FAIL beat got data=%0d last=%0b expected data=%0d last=%0b",
                   out_data, out_row_last, mon_exp.data, mon_exp.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cs = 1'b0; out_ready = 1'b0;
    sb.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic clear_codes();
    for (int i = 0; i < 2**AW; i++) code_mem[i] = '0;
  endtask

  task automatic push_expected();
    beat_t b;
    for (int t = 0; t < 2**AW; t++) begin
      if (code_mem[t] == 0) break;
      for (int e = 0; e < ED; e++) begin
        b.data = DW'(int'(code_mem[t]) * ED + e);
        b.last = (e == ED - 1);
        sb.push_back(b);
      end
    end
  endtask

  task automatic pulse_cs();
    cs = 1'b1; tick(); cs = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int n = 0;
    while (!done && n < limit) begin tick(); n++; end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_done_timeout done=%0b expected=1", name, done);
    end
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_beats_missing left=%0d expected=0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0 || token_count !== '0 ||
        code_addr !== '0 || emb_addr !== '0) begin
      failures++;
      $display("FAIL reset_state valid=%0b done=%0b cnt=%0d caddr=%0d eaddr=%0d expected all 0",
               out_valid, done, token_count, code_addr, emb_addr);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0 || code_addr !== '0) begin
      failures++;
      $display("FAIL idle_quiet valid=%0b done=%0b caddr=%0d expected 0/0/0",
               out_valid, done, code_addr);
    end
  endtask

  task automatic test_basic();
    clear_codes();
    code_mem[0] = 8'd3; code_mem[1] = 8'd5;
    do_reset();
    push_expected();
    out_ready = 1'b1;
    pulse_cs();
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early out_valid=%0b expected=0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL latency_first out_valid=%0b expected=1", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL throughput_gap out_valid=%0b expected=0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd13) begin
      failures++;
      $display("FAIL throughput_second valid=%0b data=%0d expected 1/13", out_valid, out_data);
    end
    wait_done(100, "basic");
    checks++;
    if (token_count !== 5'd2) begin
      failures++;
      $display("FAIL basic_count got=%0d expected=2", token_count);
    end
    check_sb_empty("basic");
  endtask

  task automatic test_term0();
    bit seen_valid = 0;
    clear_codes();
    do_reset();
    out_ready = 1'b1;
    pulse_cs();
    tick(); tick();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL term0_done got=%0b expected=1", done);
    end
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen_valid = 1;
      tick();
    end
    checks++;
    if (seen_valid || token_count !== '0) begin
      failures++;
      $display("FAIL term0_quiet valid_seen=%0b cnt=%0d expected 0/0", seen_valid, token_count);
    end
  endtask

  task automatic test_stall();
    clear_codes();
    code_mem[0] = 8'd1;
    do_reset();
    push_expected();
    out_ready = 1'b0;
    pulse_cs();
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd4 || emb_addr !== EW'(4)) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d valid=%0b data=%0d addr=%0d expected 1/4/4",
                 i, out_valid, out_data, emb_addr);
      end
      tick();
    end
    out_ready = 1'b1;
    wait_done(100, "stall");
    check_sb_empty("stall");
    checks++;
    if (token_count !== 5'd1) begin
      failures++;
      $display("FAIL stall_count got=%0d expected=1", token_count);
    end
  endtask

  task automatic test_full();
    bit bad = 0;
    clear_codes();
    for (int i = 0; i < 2**AW; i++) code_mem[i] = DW'(i + 1);
    do_reset();
    push_expected();
    out_ready = 1'b1;
    pulse_cs();
    wait_done(400, "full");
    check_sb_empty("full");
    checks++;
    if (token_count !== 5'd16 || code_addr !== 4'd15) begin
      failures++;
      $display("FAIL full_end cnt=%0d caddr=%0d expected 16/15", token_count, code_addr);
    end
    // Holding cs high after completion must not restart anything.
    cs = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done !== 1'b1 || out_valid !== 1'b0 || token_count !== 5'd16) bad = 1;
    end
    cs = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL cs_after_done done=%0b valid=%0b cnt=%0d expected 1/0/16",
               done, out_valid, token_count);
    end
  endtask

  task automatic test_midreset();
    int n = 0;
    clear_codes();
    code_mem[0] = 8'd2; code_mem[1] = 8'd3;
    do_reset();
    push_expected();
    out_ready = 1'b1;
    pulse_cs();
    while (!(token_count == 5'd1 && out_valid && out_data == 8'd13) && n < 100) begin
      tick(); n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL midreset_reach cnt=%0d expected mid-row of token 1", token_count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0 || token_count !== '0 ||
        code_addr !== '0 || emb_addr !== '0) begin
      failures++;
      $display("FAIL midreset_async valid=%0b done=%0b cnt=%0d caddr=%0d eaddr=%0d expected all 0",
               out_valid, done, token_count, code_addr, emb_addr);
    end
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    push_expected();
    pulse_cs();
    wait_done(100, "replay");
    check_sb_empty("replay");
    checks++;
    if (token_count !== 5'd2) begin
      failures++;
      $display("FAIL replay_count got=%0d expected=2", token_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_term0();
    test_stall();
    test_full();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
